// File: rtl/projectile.sv
// ---------------------------------------------------------------------------
// variable_pkg : shared player encodings.
// projectile   : flight model for a thrown projectile on a 1024-wide field.
//   A throw is launched from the current player's side with a power-derived
//   velocity, then integrated once every TICK_DIV clocks under constant
//   gravity (y grows downward) until it hits the opponent's target, the
//   central wall, the ground, or leaves the screen horizontally.
//
// Ports
//   clk60MHz        in   1  sole clock
//   rst             in   1  asynchronous, active-high reset
//   throw_flag      in   1  throw in progress, held until end_throw
//   power           in   4  launch power 0..15
//   current_player  in   2  thrower (PLAYER_1 / PLAYER_2)
//   proj_x          out 11  projectile x
//   proj_y          out 11  projectile y
//   proj_visible    out  1  projectile drawn
//   end_throw       out  1  one-cycle flight-finished pulse
//   hit             out  1  opponent hit, valid with end_throw
// ---------------------------------------------------------------------------
package variable_pkg;
    localparam logic [1:0] PLAYER_1 = 2'b01;
    localparam logic [1:0] PLAYER_2 = 2'b10;
endpackage

module projectile
    import variable_pkg::*;
#(
    parameter int TICK_DIV      = 1_000_000,
    parameter int P1_X          = 100,
    parameter int P2_X          = 900,
    parameter int START_Y       = 600,
    parameter int GROUND_Y      = 700,
    parameter int WALL_X_MIN    = 480,
    parameter int WALL_X_MAX    = 544,
    parameter int WALL_Y_TOP    = 450,
    parameter int TARGET_HALF_W = 32,
    parameter int TARGET_H      = 64
) (
    input  logic        clk60MHz,
    input  logic        rst,
    input  logic        throw_flag,
    input  logic [3:0]  power,
    input  logic [1:0]  current_player,
    output logic [10:0] proj_x,
    output logic [10:0] proj_y,
    output logic        proj_visible,
    output logic        end_throw,
    output logic        hit
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic signed [11:0] P1_XS    = 12'(P1_X);
    localparam logic signed [11:0] P2_XS    = 12'(P2_X);
    localparam logic signed [11:0] START_YS = 12'(START_Y);
    localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);
    localparam logic signed [11:0] TGT_TOP  = 12'(GROUND_Y - TARGET_H);
    localparam logic signed [11:0] HALF_W   = 12'(TARGET_HALF_W);
    localparam logic signed [11:0] WALL_L   = 12'(WALL_X_MIN);
    localparam logic signed [11:0] WALL_R   = 12'(WALL_X_MAX);
    localparam logic signed [11:0] WALL_T   = 12'(WALL_Y_TOP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FLY    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [11:0]      x_q, y_q, vx_q, vy_q;
    logic signed [11:0]      opp_x_q;       // centre of the target being aimed at
    logic [10:0]             proj_x_q, proj_y_q;
    logic                    vis_q, end_q, hit_q;

    logic signed [11:0]      pw_s;
    logic signed [11:0]      x_d, y_d, vy_d;
    logic                    target_s, wall_s, ground_s, offscr_s, term_s;

    // Launch power widened to signed, next kinematic step and termination tests
    always_comb begin
        pw_s     = signed'({8'd0, power});
        x_d      = x_q + vx_q;
        y_d      = y_q + vy_q;
        vy_d     = vy_q + 12'sd1;
        target_s = (x_q >= opp_x_q - HALF_W) && (x_q <= opp_x_q + HALF_W) &&
                   (y_q >= TGT_TOP) && (y_q <= GROUND_S);
        wall_s   = (x_q >= WALL_L) && (x_q <= WALL_R) && (y_q >= WALL_T);
        ground_s = (y_q >= GROUND_S);
        offscr_s = (x_q < 12'sd0) || (x_q > 12'sd1023);
        term_s   = target_s || wall_s || ground_s || offscr_s;
    end

    // Throw sequencer with registered outputs
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= 12'sd0;
            y_q      <= 12'sd0;
            vx_q     <= 12'sd0;
            vy_q     <= 12'sd0;
            opp_x_q  <= 12'sd0;
            proj_x_q <= 11'd0;
            proj_y_q <= 11'd0;
            vis_q    <= 1'b0;
            end_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            end_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    proj_x_q <= 11'd0;
                    proj_y_q <= 11'd0;
                    vis_q    <= 1'b0;
                    hit_q    <= 1'b0;
                    if (throw_flag) begin
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q <= '0;
                    y_q   <= START_YS;
                    vy_q  <= 12'sd0 - ((pw_s <<< 1) + 12'sd4);
                    if (current_player == PLAYER_1) begin
                        x_q      <= P1_XS;
                        vx_q     <= pw_s + 12'sd1;
                        opp_x_q  <= P2_XS;
                        proj_x_q <= P1_XS[10:0];
                        proj_y_q <= START_YS[10:0];
                        vis_q    <= 1'b1;
                        state_q  <= FLY;
                    end else if (current_player == PLAYER_2) begin
                        x_q      <= P2_XS;
                        vx_q     <= 12'sd0 - (pw_s + 12'sd1);
                        opp_x_q  <= P1_XS;
                        proj_x_q <= P2_XS[10:0];
                        proj_y_q <= START_YS[10:0];
                        vis_q    <= 1'b1;
                        state_q  <= FLY;
                    end else begin
                        // No valid thrower: finish immediately without a flight
                        hit_q   <= 1'b0;
                        vis_q   <= 1'b0;
                        end_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                FLY: begin
                    // Termination wins over a coincident tick so the reported
                    // position is the one that triggered it.
                    if (term_s) begin
                        hit_q   <= target_s;
                        vis_q   <= 1'b0;
                        end_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        x_q      <= x_d;
                        y_q      <= y_d;
                        vy_q     <= vy_d;
                        proj_x_q <= x_d[10:0];
                        proj_y_q <= y_d[10:0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    vis_q <= 1'b0;
                    if (!throw_flag) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign proj_x       = proj_x_q;
    assign proj_y       = proj_y_q;
    assign proj_visible = vis_q;
    assign end_throw    = end_q;
    assign hit          = hit_q;

endmodule

// File: tb/tb_projectile.sv
// Directed bench for projectile. Two instances share stimulus: u0 with the
// default geometry, u1 with player 2's target moved to x=120 so a short
// player-1 throw lands on it. Both run with TICK_DIV=4, so update n lands
// on clock 4n+2 after throw_flag is seen and end_throw rises on clock 4n+3.
module tb_projectile;
    import variable_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        throw_flag = 1'b0;
    logic [3:0]  power = 4'd0;
    logic [1:0]  current_player = PLAYER_1;
    logic [10:0] px0, py0, px1, py1;
    logic        vis0, vis1, et0, et1, hit0, hit1;

    int errors = 0;
    int checks = 0;

    int done_cyc [2];
    int rx [2];
    int ry [2];
    int rh [2];
    int pulses [2];
    int vis_ever [2];
    int ymax0;

    always #5 clk = ~clk;

    projectile #(.TICK_DIV(4)) u0 (
        .clk60MHz(clk), .rst(rst), .throw_flag(throw_flag), .power(power),
        .current_player(current_player), .proj_x(px0), .proj_y(py0),
        .proj_visible(vis0), .end_throw(et0), .hit(hit0)
    );

    projectile #(.TICK_DIV(4), .P2_X(120)) u1 (
        .clk60MHz(clk), .rst(rst), .throw_flag(throw_flag), .power(power),
        .current_player(current_player), .proj_x(px1), .proj_y(py1),
        .proj_visible(vis1), .end_throw(et1), .hit(hit1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise throw_flag and record each instance's end_throw event.
    task automatic run_throw(input int budget, input int drop_at, input int scramble_at);
        for (int i = 0; i < 2; i++) begin
            done_cyc[i] = -1; rx[i] = -1; ry[i] = -1; rh[i] = -1;
            pulses[i] = 0; vis_ever[i] = 0;
        end
        ymax0 = 0;
        throw_flag = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (et0) begin
                pulses[0]++;
                if (done_cyc[0] < 0) begin
                    done_cyc[0] = k; rx[0] = int'(px0); ry[0] = int'(py0); rh[0] = int'(hit0);
                end
            end
            if (et1) begin
                pulses[1]++;
                if (done_cyc[1] < 0) begin
                    done_cyc[1] = k; rx[1] = int'(px1); ry[1] = int'(py1); rh[1] = int'(hit1);
                end
            end
            if (vis0) begin
                vis_ever[0] = 1;
                if (int'(py0) > ymax0) ymax0 = int'(py0);
            end
            if (vis1) vis_ever[1] = 1;
            if (k == drop_at) throw_flag = 1'b0;
            if (k == scramble_at) begin
                power = ~power;
                current_player = 2'b11;
            end
            if (done_cyc[0] >= 0 && done_cyc[1] >= 0 &&
                k >= done_cyc[0] + 4 && k >= done_cyc[1] + 4) break;
        end
        throw_flag = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_px", int'(px0), 0);
        chk("rst_py", int'(py0), 0);
        chk("rst_vis", int'(vis0), 0);
        chk("rst_end", int'(et0), 0);
        chk("rst_hit", int'(hit0), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Player 1, power 0: u0 grounds at tick 20, u1 hits its target at tick 15
        current_player = PLAYER_1; power = 4'd0;
        run_throw(300, 0, 0);
        chk("gnd_cyc", done_cyc[0], 83);
        chk("gnd_x", rx[0], 120);
        chk("gnd_y", ry[0], 710);
        chk("gnd_hit", rh[0], 0);
        chk("gnd_pulses", pulses[0], 1);
        chk("tgt_cyc", done_cyc[1], 63);
        chk("tgt_x", rx[1], 115);
        chk("tgt_y", ry[1], 645);
        chk("tgt_hit", rh[1], 1);
        chk("tgt_pulses", pulses[1], 1);
        chk("idle_px", int'(px0), 0);
        chk("idle_py", int'(py0), 0);
        chk("idle_vis", int'(vis0), 0);
        chk("idle_hit", int'(hit1), 0);

        // Player 1, power 8: wall at tick 43; inputs scrambled mid-flight
        current_player = PLAYER_1; power = 4'd8;
        run_throw(300, 0, 20);
        chk("wall_cyc", done_cyc[0], 175);
        chk("wall_x", rx[0], 487);
        chk("wall_y", ry[0], 643);
        chk("wall_hit", rh[0], 0);
        chk("wall_pulses", pulses[0], 1);

        // Player 1, power 15: off-screen at tick 58; throw_flag dropped mid-flight
        current_player = PLAYER_1; power = 4'd15;
        run_throw(300, 30, 0);
        chk("off_cyc", done_cyc[0], 235);
        chk("off_x", rx[0], 1028);
        chk("off_y", ry[0], 281);
        chk("off_hit", rh[0], 0);
        chk("off_pulses", pulses[0], 1);
        chk("off_y_nonneg", int'(ymax0 < 1024), 1);

        // Player 2, power 0: u0 grounds at x=880; u1 launches at 120 and hits P1 target
        current_player = PLAYER_2; power = 4'd0;
        run_throw(300, 0, 0);
        chk("p2_gnd_cyc", done_cyc[0], 83);
        chk("p2_gnd_x", rx[0], 880);
        chk("p2_gnd_y", ry[0], 710);
        chk("p2_gnd_hit", rh[0], 0);
        chk("p2_tgt_x", rx[1], 105);
        chk("p2_tgt_y", ry[1], 645);
        chk("p2_tgt_hit", rh[1], 1);

        // Invalid thrower codes finish straight away without flying
        current_player = 2'b11; power = 4'd5;
        run_throw(50, 0, 0);
        chk("inv11_cyc", done_cyc[0], 2);
        chk("inv11_hit", rh[0], 0);
        chk("inv11_vis", vis_ever[0], 0);
        chk("inv11_pulses", pulses[0], 1);
        current_player = 2'b00;
        run_throw(50, 0, 0);
        chk("inv00_cyc", done_cyc[0], 2);
        chk("inv00_vis", vis_ever[0], 0);

        // Reset at tick 10 of the power-0 flight, then a fresh flight
        current_player = PLAYER_1; power = 4'd0;
        throw_flag = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk); #1;
        end
        chk("t10_x", int'(px0), 110);
        chk("t10_y", int'(py0), 605);
        chk("t10_vis", int'(vis0), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_px", int'(px0), 0);
        chk("mid_rst_py", int'(py0), 0);
        chk("mid_rst_vis", int'(vis0), 0);
        chk("mid_rst_end", int'(et0), 0);
        chk("mid_rst_hit", int'(hit0), 0);
        @(posedge clk); #1;
        chk("mid_rst_end2", int'(et0), 0);
        rst = 1'b0;
        run_throw(300, 0, 0);
        chk("rerun_cyc", done_cyc[0], 83);
        chk("rerun_x", rx[0], 120);
        chk("rerun_y", ry[0], 710);
        chk("rerun_pulses", pulses[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/projectile.md
PROJECTILE -- requirements
Module: projectile

Interface
REQ-001 The block SHALL expose these parameters:
- TICK_DIV, 1_000_000, clock cycles per flight update (60 Hz at 60 MHz).
- P1_X, 100, player-1 launch and target centre x.
- P2_X, 900, player-2 launch and target centre x.
- START_Y, 600, launch y.
- GROUND_Y, 700, ground line y.
- WALL_X_MIN, 480, wall left x.
- WALL_X_MAX, 544, wall right x.
- WALL_Y_TOP, 450, wall top y.
- TARGET_HALF_W, 32, target half-width.
- TARGET_H, 64, target height above GROUND_Y.
REQ-002 The block SHALL have these ports, with y increasing downward:
- clk60MHz  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- throw_flag  in  1  throw in progress, held until end_throw.
- power  in  4  launch power 0..15.
- current_player  in  2  thrower, PLAYER_1 or PLAYER_2 from variable_pkg.
- proj_x  out  11  projectile x.
- proj_y  out  11  projectile y.
- proj_visible  out  1  projectile drawn.
- end_throw  out  1  one-cycle flight-finished pulse.
- hit  out  1  opponent hit, valid only with end_throw.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, LAUNCH, FLY, DONE; all outputs SHALL be registered.
REQ-004 IDLE: if throw_flag=1, go to LAUNCH; otherwise stay; proj_x=proj_y=0, proj_visible=0.
REQ-005 LAUNCH (one cycle), when current_player is PLAYER_1 or PLAYER_2:
- PLAYER_1: x=P1_X, vx=+(power+1).
- PLAYER_2: x=P2_X, vx=-(power+1).
- y=START_Y, vy=-(2*power+4), tick counter cleared.
- Next state FLY with proj_visible=1.
REQ-006 LAUNCH with current_player 2'b00 or 2'b11: go directly to DONE with hit=0 and no flight.
REQ-007 Internal x, y, vx, vy SHALL be signed 12-bit; proj_x/proj_y SHALL be x[10:0]/y[10:0].
REQ-008 FLY, counter and update rule:
- Counter increments every cycle.
- When counter reaches TICK_DIV-1, it wraps to 0 and one update occurs in the same edge: x+=vx, y+=vy, vy+=1.
REQ-009 FLY termination, evaluated every cycle on registered x,y, first match wins (priority order):
- Target hit when x is within opponent centre ±TARGET_HALF_W and GROUND_Y-TARGET_H <= y <= GROUND_Y: hit=1.
- Wall hit when WALL_X_MIN <= x <= WALL_X_MAX and y >= WALL_Y_TOP.
- Ground when y >= GROUND_Y.
- Off-screen when x < 0 or x > 1023.
- On any match go to DONE; y < 0 alone SHALL NOT terminate.
REQ-010 The first termination check SHALL be made one cycle after entry to FLY; the launch position never self-hits.
REQ-011 DONE: end_throw=1 for exactly the DONE-entry cycle.
- hit set per REQ-009; proj_x/proj_y hold the last position; proj_visible=0.
- Stay in DONE until throw_flag=0, then go to IDLE.
- end_throw SHALL NOT re-pulse while waiting.
REQ-012 power and current_player SHALL be sampled only in LAUNCH; changes during FLY SHALL be ignored.
REQ-013 throw_flag falling during FLY SHALL be ignored; flight completes normally.

Reset
REQ-014 rst=1 SHALL immediately set state=IDLE and zero proj_x, proj_y, proj_visible, end_throw, hit, counter, x, y, vx, vy.
REQ-015 Reset mid-flight SHALL abort without an end_throw pulse; after release the block waits in IDLE.

Verification (TICK_DIV=4 unless stated)
REQ-016 PLAYER_1, power=0, throw_flag held -> ground at tick 20: end_throw 1 cycle, hit=0, proj_x=120, proj_y=710.
REQ-017 PLAYER_1, power=8 -> wall at tick 43: proj_x=487, proj_y=643, hit=0.
REQ-018 PLAYER_1, power=15 -> off-screen at tick 58: proj_x=1028, proj_y=281, hit=0; y stays >= 0 on the way.
REQ-019 P2_X=120 override, PLAYER_1, power=0 -> target hit at tick 15: proj_x=115, proj_y=645, hit=1.
REQ-020 current_player=2'b11 with throw_flag=1 -> end_throw two cycles after throw_flag is seen, hit=0, proj_visible never 1.
REQ-021 rst pulsed at tick 10 of REQ-016 -> all outputs 0 immediately, no end_throw; throw_flag held high -> new flight restarts from LAUNCH.
